// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits retired per RUN cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr_en,
  input  logic             lo_wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q;
  logic [WIDTH-1:0]       a_q, b_q, mag_b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]     acc_q, acc_step, prod;
  logic                   neg_res_q, neg_rem_q, dbz_q;
  logic [CntW-1:0]        cnt_q;
  logic [WIDTH-1:0]       mag_a, mag_b, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0]         part, trial, sum;
  logic                   is_div, is_signed, idle_like;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StDone:  state_d = start ? StPrep : StIdle;
      StPrep:  state_d = StRun;
      StRun:   if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    unique case (state_q)
      StPrep, StRun, StFix: busy = 1'b1;
      StDone: begin
        done        = 1'b1;
        div_by_zero = dbz_q;
      end
      default: ;
    endcase
  end

  // Magnitudes of the latched operands; unsigned ops pass straight through.
  always_comb begin
    mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    acc_step = acc_q;
    part     = '0;
    trial    = '0;
    sum      = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (is_div) begin
        part     = {acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1]};
        trial    = part - {1'b0, mag_b_q};
        acc_step = {acc_step[2*WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
          acc_step[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
          acc_step[0]               = 1'b1;
        end
      end else begin
        sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} + (acc_step[0] ? {1'b0, mag_b_q} : '0);
        acc_step = {sum, acc_step[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end else begin
            if (hi_wr_en) hi_q <= wr_data;
            if (lo_wr_en) lo_q <= wr_data;
          end
        end
        StPrep: begin
          acc_q     <= {{WIDTH{1'b0}}, mag_a};
          mag_b_q   <= mag_b;
          neg_res_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= is_signed && a_q[WIDTH-1];
          cnt_q     <= CntW'(N);
        end
        StRun: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CntW'(1);
        end
        StFix: begin
          hi_q  <= fix_hi;
          lo_q  <= fix_lo;
          dbz_q <= is_div && (b_q == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit: 32-bit/1-bit and 16-bit/2-bit builds.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        start, hi_wr_en, lo_wr_en, busy, done, dbz;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data, hi, lo;

  logic        start16, busy16, done16, dbz16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr_en(hi_wr_en), .lo_wr_en(lo_wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .hi_wr_en(1'b0), .lo_wr_en(1'b0), .wr_data(16'h0),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int c0);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    c0    = cyc;
    @(negedge clk);
    start    = 1'b0;
    hi_wr_en = 1'b0;
    lo_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = cyc - c0;
  endtask

  task automatic wait_done16(input int c0, output int lat);
    int k = 0;
    while (!done16 && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = cyc - c0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, lat, pulses;
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{2'b10, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    vecs[6]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{2'b01, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[8]  = '{2'b11, 32'hFFFFFFF8, 32'h0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{2'b00, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};

    start = 0; hi_wr_en = 0; lo_wr_en = 0; op = 0; a = 0; b = 0; wr_data = 0;
    start16 = 0; op16 = 0; a16 = 0; b16 = 0;

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy16", busy16, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, c0);
      chk($sformatf("v%0d busy", i), busy, 1);
      wait_done(c0, lat);
      chk($sformatf("v%0d latency", i), lat, 35);
      chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d dbz", i), dbz, vecs[i].dbz);
      @(negedge clk);
      chk($sformatf("v%0d done pulse", i), done, 0);
    end

    // start and MTHI during RUN are both ignored
    launch(2'b10, 32'd100, 32'd7, c0);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h3; b = 32'h3; hi_wr_en = 1'b1; wr_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_wr_en = 1'b0;
    chk("run ignore busy", busy, 1);
    chk("run ignore hi", hi, 32'hFFFFFFFE);
    wait_done(c0, lat);
    chk("run ignore latency", lat, 35);
    chk("run ignore hi result", hi, 2);
    chk("run ignore lo result", lo, 14);
    @(negedge clk);
    chk("run ignore no restart", busy, 0);

    // MTLO in IDLE, then MTHI+MTLO together
    lo_wr_en = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    lo_wr_en = 1'b0;
    chk("mtlo lo", lo, 32'h55);
    chk("mtlo hi kept", hi, 2);
    hi_wr_en = 1'b1; lo_wr_en = 1'b1; wr_data = 32'h77;
    @(negedge clk);
    hi_wr_en = 1'b0; lo_wr_en = 1'b0;
    chk("mthi+mtlo hi", hi, 32'h77);
    chk("mthi+mtlo lo", lo, 32'h77);

    // start with MTLO: start wins
    lo_wr_en = 1'b1; wr_data = 32'hAAAA;
    launch(2'b00, 32'd3, 32'd5, c0);
    chk("start+mtlo dropped", lo, 32'h77);
    chk("start+mtlo busy", busy, 1);
    wait_done(c0, lat);
    chk("start+mtlo latency", lat, 35);
    chk("start+mtlo hi", hi, 0);
    chk("start+mtlo lo", lo, 15);

    // reset during the 10th RUN cycle
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, c0);
    repeat (10) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid reset busy", busy, 0);
    chk("mid reset hi", hi, 0);
    chk("mid reset lo", lo, 0);
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("mid reset no done", pulses, 0);

    // 16-bit, 2 bits per cycle, with back-to-back start in DONE
    start16 = 1'b1; op16 = 2'b01; a16 = 16'h8000; b16 = 16'h8000; c0 = cyc;
    @(negedge clk);
    start16 = 1'b0;
    chk("w16 busy", busy16, 1);
    wait_done16(c0, lat);
    chk("w16 latency", lat, 11);
    chk("w16 hi", hi16, 16'h4000);
    chk("w16 lo", lo16, 16'h0000);
    start16 = 1'b1; op16 = 2'b00; a16 = 16'h00FF; b16 = 16'h0101; c0 = cyc;
    @(negedge clk);
    start16 = 1'b0;
    chk("b2b busy", busy16, 1);
    chk("b2b done low", done16, 0);
    wait_done16(c0, lat);
    chk("b2b latency", lat, 11);
    chk("b2b hi", hi16, 16'h0000);
    chk("b2b lo", lo16, 16'hFFFF);
    start16 = 1'b1; op16 = 2'b11; a16 = 16'hFFF9; b16 = 16'h0002; c0 = cyc;
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(c0, lat);
    chk("w16 div latency", lat, 11);
    chk("w16 div hi", hi16, 16'hFFFF);
    chk("w16 div lo", lo16, 16'hFFFD);
    chk("w16 div dbz", dbz16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
